// File: rtl/mfx_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mfx_step_sequencer
//  Brief    : Control-step sequencer for the Mini SRC instruction fetch
//             (T0-T2) and the HI/LO move execute step (T3) covering mfhi,
//             mflo, mthi and mtlo. Each T-step is held STEP_CYCLES clocks;
//             the fetch read in T1 waits on mem_ready with an optional
//             timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module mfx_step_sequencer #(
    parameter int         STEP_CYCLES = 2,
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [4:0] OP_MFHI     = 5'b11000,
    parameter logic [4:0] OP_MFLO     = 5'b11001,
    parameter logic [4:0] OP_MTHI     = 5'b10110,
    parameter logic [4:0] OP_MTLO     = 5'b10111
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir_data,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        mem_err,
    // T0 strobes
    output logic        PC_out,
    output logic        MAR_in,
    output logic        IncPC,
    output logic        Z_in,
    // T1 strobes
    output logic        Zlow_out,
    output logic        PC_in,
    output logic        Read,
    output logic        MDR_in,
    // T2 strobes
    output logic        MDR_out,
    output logic        IR_in,
    // T3 strobes
    output logic        Gra,
    output logic        Rin,
    output logic        Rout,
    output logic        HI_in,
    output logic        HI_out,
    output logic        LO_in,
    output logic        LO_out
);

    // ------------------------------------------------------------------------
    // Counter sizing: wide enough for both the step hold and the T1 timeout,
    // plus headroom so the saturation value is never a compare target.
    // ------------------------------------------------------------------------
    localparam int c_CNT_MAX = (MEM_TIMEOUT > STEP_CYCLES) ? MEM_TIMEOUT : STEP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT   = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_STEP_LAST = c_CNT_W'(STEP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam bit                 c_TO_EN     = (MEM_TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [4:0]           w_opcode;
    logic                 w_step_end;
    logic                 w_unused_ir;

    assign w_opcode    = ir_data[31:27];
    assign w_unused_ir = ^ir_data[26:0];
    assign w_step_end  = (r_cnt == c_STEP_LAST);

    // State register and step counter; counter restarts on every state change
    // and saturates instead of wrapping while a state is held.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // Next-state selection and Moore strobe decode (T3 strobes follow the
    // opcode held in the IR, which is stable because IR_in is low in T3).
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        illegal      = 1'b0;
        mem_err      = 1'b0;
        PC_out       = 1'b0;
        MAR_in       = 1'b0;
        IncPC        = 1'b0;
        Z_in         = 1'b0;
        Zlow_out     = 1'b0;
        PC_in        = 1'b0;
        Read         = 1'b0;
        MDR_in       = 1'b0;
        MDR_out      = 1'b0;
        IR_in        = 1'b0;
        Gra          = 1'b0;
        Rin          = 1'b0;
        Rout         = 1'b0;
        HI_in        = 1'b0;
        HI_out       = 1'b0;
        LO_in        = 1'b0;
        LO_out       = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_T0;
                end
            end

            S_T0: begin
                PC_out = 1'b1;
                MAR_in = 1'b1;
                IncPC  = 1'b1;
                Z_in   = 1'b1;
                if (w_step_end) begin
                    w_next_state = S_T1;
                end
            end

            S_T1: begin
                Zlow_out = 1'b1;
                PC_in    = 1'b1;
                Read     = 1'b1;
                MDR_in   = 1'b1;
                // Data-ready wins over the timeout on the same edge.
                if ((r_cnt >= c_STEP_LAST) && mem_ready) begin
                    w_next_state = S_T2;
                end else if (c_TO_EN && (r_cnt == c_TO_LAST) && !mem_ready) begin
                    w_next_state = S_ERR;
                end
            end

            S_T2: begin
                MDR_out = 1'b1;
                IR_in   = 1'b1;
                if (w_step_end) begin
                    w_next_state = S_T3;
                end
            end

            S_T3: begin
                if (w_opcode == OP_MFHI) begin
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                    HI_out = 1'b1;
                    if (w_step_end) w_next_state = S_DONE;
                end else if (w_opcode == OP_MFLO) begin
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                    LO_out = 1'b1;
                    if (w_step_end) w_next_state = S_DONE;
                end else if (w_opcode == OP_MTHI) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    HI_in = 1'b1;
                    if (w_step_end) w_next_state = S_DONE;
                end else if (w_opcode == OP_MTLO) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    LO_in = 1'b1;
                    if (w_step_end) w_next_state = S_DONE;
                end else begin
                    // Unsupported opcode: flag it on the first T3 cycle and
                    // abandon the instruction without a done pulse.
                    illegal      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end

            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end

            S_ERR: begin
                mem_err      = 1'b1;
                w_next_state = S_IDLE;
            end

            default: begin
                busy         = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mfx_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mfx_step_sequencer
//  Brief    : Directed self-checking bench for mfx_step_sequencer using the
//             default parameters (STEP_CYCLES=2, MEM_TIMEOUT=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mfx_step_sequencer;

    logic        clk;
    logic        clr;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir_data;
    logic        busy, done, illegal, mem_err;
    logic        PC_out, MAR_in, IncPC, Z_in;
    logic        Zlow_out, PC_in, Read, MDR_in;
    logic        MDR_out, IR_in;
    logic        Gra, Rin, Rout, HI_in, HI_out, LO_in, LO_out;

    int n_checks;
    int n_fail;

    // Observed outputs packed as {status[4] | T0[4] | T1[4] | T2[2] | T3[7]}
    logic [20:0] w_obs;
    assign w_obs = {busy, done, illegal, mem_err,
                    PC_out, MAR_in, IncPC, Z_in,
                    Zlow_out, PC_in, Read, MDR_in,
                    MDR_out, IR_in,
                    Gra, Rin, Rout, HI_in, HI_out, LO_in, LO_out};

    // Hand-derived expected output patterns per state
    localparam logic [20:0] E_IDLE = 21'b0000_0000_0000_00_0000000;
    localparam logic [20:0] E_T0   = 21'b1000_1111_0000_00_0000000;
    localparam logic [20:0] E_T1   = 21'b1000_0000_1111_00_0000000;
    localparam logic [20:0] E_T2   = 21'b1000_0000_0000_11_0000000;
    localparam logic [20:0] E_MFHI = 21'b1000_0000_0000_00_1100100;
    localparam logic [20:0] E_MFLO = 21'b1000_0000_0000_00_1100001;
    localparam logic [20:0] E_MTHI = 21'b1000_0000_0000_00_1011000;
    localparam logic [20:0] E_MTLO = 21'b1000_0000_0000_00_1010010;
    localparam logic [20:0] E_DONE = 21'b1100_0000_0000_00_0000000;
    localparam logic [20:0] E_ILL  = 21'b1010_0000_0000_00_0000000;
    localparam logic [20:0] E_ERR  = 21'b1001_0000_0000_00_0000000;

    mfx_step_sequencer #(
        .STEP_CYCLES (2),
        .MEM_TIMEOUT (16)
    ) u_dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .mem_ready (mem_ready),
        .ir_data   (ir_data),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .mem_err   (mem_err),
        .PC_out    (PC_out),
        .MAR_in    (MAR_in),
        .IncPC     (IncPC),
        .Z_in      (Z_in),
        .Zlow_out  (Zlow_out),
        .PC_in     (PC_in),
        .Read      (Read),
        .MDR_in    (MDR_in),
        .MDR_out   (MDR_out),
        .IR_in     (IR_in),
        .Gra       (Gra),
        .Rin       (Rin),
        .Rout      (Rout),
        .HI_in     (HI_in),
        .HI_out    (HI_out),
        .LO_in     (LO_in),
        .LO_out    (LO_out)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction with mem_ready high; optionally pulses start in T2
    task automatic run_normal(input string tag, input logic [31:0] ir,
                              input logic [20:0] e_t3, input bit poke);
        logic [20:0] exp_seq [0:10];
        exp_seq = '{E_T0, E_T0, E_T1, E_T1, E_T2, E_T2, e_t3, e_t3, E_DONE, E_IDLE, E_IDLE};
        ir_data   = ir;
        mem_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("%s_c%0d", tag, i + 1), {11'd0, w_obs}, {11'd0, exp_seq[i]});
            start = poke && ((i == 4) || (i == 5));
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        clr       = 1'b0;
        start     = 1'b1;
        mem_ready = 1'b1;
        ir_data   = 32'h0;

        // Reset held two cycles with start asserted
        step();
        chk("rst_c1", {11'd0, w_obs}, {11'd0, E_IDLE});
        step();
        chk("rst_c2", {11'd0, w_obs}, {11'd0, E_IDLE});
        clr   = 1'b1;
        start = 1'b0;
        step();
        chk("idle_a", {11'd0, w_obs}, {11'd0, E_IDLE});
        step();
        chk("idle_b", {11'd0, w_obs}, {11'd0, E_IDLE});

        // Legal moves, back to back
        run_normal("mfhi", 32'hC200_0000, E_MFHI, 1'b0);
        run_normal("mthi", 32'hB200_0000, E_MTHI, 1'b0);
        run_normal("mtlo", 32'hBA00_0000, E_MTLO, 1'b0);

        // T1 stretched: mem_ready low for the first 4 T1 cycles
        ir_data = 32'hC200_0000;
        start   = 1'b1;
        step();
        start     = 1'b0;
        mem_ready = 1'b0;
        chk("wait_t0a", {11'd0, w_obs}, {11'd0, E_T0});
        step();
        chk("wait_t0b", {11'd0, w_obs}, {11'd0, E_T0});
        step();
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) mem_ready = 1'b1;
            chk($sformatf("wait_t1_%0d", i), {11'd0, w_obs}, {11'd0, E_T1});
            step();
        end
        chk("wait_t2a", {11'd0, w_obs}, {11'd0, E_T2});
        step();
        chk("wait_t2b", {11'd0, w_obs}, {11'd0, E_T2});
        step();
        chk("wait_t3a", {11'd0, w_obs}, {11'd0, E_MFHI});
        step();
        chk("wait_t3b", {11'd0, w_obs}, {11'd0, E_MFHI});
        step();
        chk("wait_done", {11'd0, w_obs}, {11'd0, E_DONE});
        step();
        chk("wait_idle", {11'd0, w_obs}, {11'd0, E_IDLE});

        // Timeout: mem_ready never arrives
        start = 1'b1;
        step();
        start     = 1'b0;
        mem_ready = 1'b0;
        chk("to_t0a", {11'd0, w_obs}, {11'd0, E_T0});
        step();
        chk("to_t0b", {11'd0, w_obs}, {11'd0, E_T0});
        step();
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("to_t1_%0d", i), {11'd0, w_obs}, {11'd0, E_T1});
            step();
        end
        chk("to_err", {11'd0, w_obs}, {11'd0, E_ERR});
        step();
        chk("to_idle", {11'd0, w_obs}, {11'd0, E_IDLE});
        mem_ready = 1'b1;
        step();
        chk("to_idle2", {11'd0, w_obs}, {11'd0, E_IDLE});

        // Illegal opcode then a normal run
        ir_data = 32'h0000_0000;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("ill_t0a", {11'd0, w_obs}, {11'd0, E_T0});
        step();
        chk("ill_t0b", {11'd0, w_obs}, {11'd0, E_T0});
        step();
        chk("ill_t1a", {11'd0, w_obs}, {11'd0, E_T1});
        step();
        chk("ill_t1b", {11'd0, w_obs}, {11'd0, E_T1});
        step();
        chk("ill_t2a", {11'd0, w_obs}, {11'd0, E_T2});
        step();
        chk("ill_t2b", {11'd0, w_obs}, {11'd0, E_T2});
        step();
        chk("ill_t3", {11'd0, w_obs}, {11'd0, E_ILL});
        step();
        chk("ill_idle", {11'd0, w_obs}, {11'd0, E_IDLE});
        run_normal("mflo", 32'hC800_0000, E_MFLO, 1'b0);

        // Reset during the second T1 cycle
        ir_data = 32'hC200_0000;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("mid_t0a", {11'd0, w_obs}, {11'd0, E_T0});
        step();
        chk("mid_t0b", {11'd0, w_obs}, {11'd0, E_T0});
        step();
        chk("mid_t1a", {11'd0, w_obs}, {11'd0, E_T1});
        step();
        chk("mid_t1b", {11'd0, w_obs}, {11'd0, E_T1});
        clr = 1'b0;
        step();
        chk("mid_rst", {11'd0, w_obs}, {11'd0, E_IDLE});
        clr = 1'b1;
        step();
        chk("mid_idle", {11'd0, w_obs}, {11'd0, E_IDLE});

        // start pulses during T2 must be ignored
        run_normal("ign", 32'hC200_0000, E_MFHI, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mfx_step_sequencer.md
Name: mfx_step_sequencer

Overview:
- Parametrised control-step sequencer that generates bus/register control strobes for the Mini SRC fetch (T0-T2) and the HI/LO move execute step (T3).
- Supports mfhi, mflo, mthi and mtlo, with a configurable per-step hold length and a memory-ready handshake on the fetch read.
- Sits between the datapath control inputs and the top-level/control unit.
- Replaces hand-sequenced strobes for these instructions.

Parameters:
- STEP_CYCLES, 2: clocks each T-step is held (>=1).
- MEM_TIMEOUT, 16: max T1 cycles waiting for mem_ready before abort; 0 disables the timeout.
- OP_MFHI, 5'b11000: opcode field value for mfhi.
- OP_MFLO, 5'b11001: opcode for mflo.
- OP_MTHI, 5'b10110: opcode for mthi.
- OP_MTLO, 5'b10111: opcode for mtlo.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clr  in  1  synchronous reset, active-low.
- start  in  1  begin one instruction; sampled only in IDLE.
- mem_ready  in  1  RAM read data valid.
- ir_data  in  32  IR register contents; opcode = ir_data[31:27].
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- mem_err  out  1  one-cycle pulse on T1 timeout.
- PC_out, MAR_in, IncPC, Z_in  out  1 each  T0 strobes.
- Zlow_out, PC_in, Read, MDR_in  out  1 each  T1 strobes.
- MDR_out, IR_in  out  1 each  T2 strobes.
- Gra, Rin, Rout, HI_in, HI_out, LO_in, LO_out  out  1 each  T3 strobes.

Behaviour:
- Moore machine. States: IDLE, T0, T1, T2, T3, DONE, ERR. Step counter cnt is cleared on every state entry.
- clr=0 at a posedge: state goes to IDLE, cnt=0, and every output is 0 from the next cycle. This holds in any state, including mid-instruction. No partial strobes survive reset.
- IDLE: start=1 at an edge moves to T0. start is ignored in every other state.
- T0: asserts PC_out, MAR_in, IncPC and Z_in. Exits to T1 when cnt==STEP_CYCLES-1.
- T1: asserts Zlow_out, PC_in, Read and MDR_in.
  - Exits to T2 at the edge where cnt>=STEP_CYCLES-1 and mem_ready=1.
  - If MEM_TIMEOUT>0 and cnt==MEM_TIMEOUT-1 with mem_ready=0, exits to ERR.
  - cnt saturates; it does not wrap.
- T2: asserts MDR_out and IR_in. Exits to T3 when cnt==STEP_CYCLES-1.
- T3: decodes opcode combinationally from ir_data[31:27]. ir_data must be stable because IR_in is low in T3.
  - OP_MFHI: Gra, Rin, HI_out.
  - OP_MFLO: Gra, Rin, LO_out.
  - OP_MTHI: Gra, Rout, HI_in.
  - OP_MTLO: Gra, Rout, LO_in.
  - Legal opcode: exits to DONE when cnt==STEP_CYCLES-1.
  - Any other opcode: no T3 strobes; illegal=1 for exactly the first T3 cycle; next edge goes to IDLE with no done.
- DONE: done=1 for one cycle, then IDLE. A new start is accepted on the cycle after DONE, giving back-to-back spacing of 1 IDLE cycle.
- ERR: mem_err=1 for one cycle, all strobes 0, then IDLE.
- Strobe groups are mutually exclusive by state. No strobe is ever asserted in IDLE, DONE or ERR.
- Latency with mem_ready=1 throughout: 4*STEP_CYCLES+1 busy cycles from the start edge to the end of done.

Test Plan:
1. Reset: hold clr=0 for 2 cycles, with start=1 during reset -> all outputs 0, busy=0; after releasing clr, machine stays in IDLE until start is seen with clr=1.
2. mfhi, STEP_CYCLES=2, mem_ready=1, ir_data=0xC2000000 -> each strobe group is high for exactly 2 cycles, in order: T0 group cycles 1-2, T1 group 3-4, T2 group 5-6, Gra/Rin/HI_out 7-8; done pulses in cycle 9; busy high for 9 cycles.
3. mthi ir_data=0xB2000000 and mtlo ir_data=0xBA000000 -> T3 asserts Gra/Rout/HI_in and Gra/Rout/LO_in respectively; Rin, HI_out and LO_out stay 0.
4. mem_ready low for the first 4 T1 cycles, then high -> T1 lasts 5 cycles, then T2 proceeds. mem_ready held low with MEM_TIMEOUT=16 -> mem_err pulses after 16 T1 cycles, return to IDLE, no done.
5. ir_data=0x00000000 -> illegal pulses for 1 cycle in T3, no T3 strobes, no done, then IDLE; a following start runs normally.
6. clr=0 during the 2nd T1 cycle -> Read and MDR_in drop the next cycle, busy=0; start pulses issued during T2 of a normal run are ignored, and no second instruction starts.
